// File: rtl/ctrl_bubble_pkg.sv
// Shared types and helpers for the ID->EX bubble-insertion stage.
package ctrl_bubble_pkg;

  // Stage control states: normal flow or inserting hazard bubbles.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // Default ceiling on bubbles for a single hazard request.
  localparam int STALL_MAX_DEFAULT = 3;

  // Number of bits needed to encode values 0..v-1 (v >= 2 in practice).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ctrl_bubble_stage_counter.sv
// Remaining-bubble counter for ctrl_bubble_stage.
// Priority: clear > load > decrement > hold. done flags the final bubble (cnt == 1).
import ctrl_bubble_pkg::*;

module bubble_stall_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  // Track how many bubbles remain after the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1'b1);
    end else begin
      cnt <= cnt;
    end
  end

  assign done = (cnt == CNT_W'(1'b1));

endmodule

// File: rtl/ctrl_bubble_stage.sv
// ID->EX control register with hazard bubble insertion, flush and hold.
// Each cycle: flush > hold > hazard > pass.
// Optional build macro CTRL_BUBBLE_STATS_EN adds stats_clr / bubble_cnt
// (saturating 16-bit count of registered bubbles).
import ctrl_bubble_pkg::*;

module ctrl_bubble_stage #(
  parameter  int                CTRL_W      = 32,
  parameter  int                STALL_MAX   = STALL_MAX_DEFAULT,
  parameter  logic [CTRL_W-1:0] BUBBLE_MASK = {CTRL_W{1'b1}},
  localparam int                CNT_W       = clog2(STALL_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CTRL_BUBBLE_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       bubble_cnt,
`endif
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  input  logic              hazard,
  input  logic [CNT_W-1:0]  stall_cycles,
  input  logic              flush,
  input  logic              hold,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic              stall_req
);

  localparam logic [CNT_W-1:0] STALL_MAX_C = CNT_W'(STALL_MAX);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_s;
  logic             cnt_done_s;
  logic             cnt_clr_s;
  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic [CNT_W-1:0] cnt_load_val_s;
  logic [CNT_W-1:0] eff_s;
  logic             bubble_s;
  logic             pass_s;
  logic             stall_req_s;

  // Requested bubble count clamped to the configured ceiling.
  assign eff_s = (stall_cycles > STALL_MAX_C) ? STALL_MAX_C : stall_cycles;

  bubble_stall_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr_s),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .dec      (cnt_dec_s),
    .cnt      (cnt_s),
    .done     (cnt_done_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, counter control and stage action selection.
  always_comb begin
    state_nxt_s    = state_r;
    bubble_s       = 1'b0;
    pass_s         = 1'b0;
    stall_req_s    = 1'b0;
    cnt_clr_s      = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_dec_s      = 1'b0;
    cnt_load_val_s = {CNT_W{1'b0}};
    if (flush) begin
      bubble_s    = 1'b1;
      cnt_clr_s   = 1'b1;
      state_nxt_s = RUN;
    end else if (hold) begin
      // Downstream frozen: keep everything, keep the front end held too.
      stall_req_s = 1'b1;
    end else begin
      case (state_r)
        STALL: begin
          bubble_s    = 1'b1;
          stall_req_s = 1'b1;
          if (cnt_done_s) begin
            cnt_clr_s   = 1'b1;
            state_nxt_s = RUN;
          end else begin
            cnt_dec_s = 1'b1;
          end
        end
        RUN: begin
          if (hazard && valid_in && (stall_cycles != {CNT_W{1'b0}})) begin
            bubble_s       = 1'b1;
            stall_req_s    = 1'b1;
            cnt_load_s     = 1'b1;
            cnt_load_val_s = eff_s - CNT_W'(1'b1);
            if (eff_s > CNT_W'(1'b1)) begin
              state_nxt_s = STALL;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            pass_s = 1'b1;
          end
        end
        default: begin
          bubble_s    = 1'b1;
          cnt_clr_s   = 1'b1;
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // stall_req must read low for the whole time reset is applied.
  assign stall_req = stall_req_s & ~rst;

  // Pipeline register toward EX: bubble, pass, or keep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_out  <= {CTRL_W{1'b0}};
      valid_out <= 1'b0;
    end else if (bubble_s) begin
      ctrl_out  <= ctrl_in & ~BUBBLE_MASK;
      valid_out <= 1'b0;
    end else if (pass_s) begin
      ctrl_out  <= ctrl_in;
      valid_out <= valid_in;
    end else begin
      ctrl_out  <= ctrl_out;
      valid_out <= valid_out;
    end
  end

`ifdef CTRL_BUBBLE_STATS_EN
  // Saturating bubble counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= 16'h0000;
    end else if (stats_clr) begin
      bubble_cnt <= 16'h0000;
    end else if (bubble_s && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'h0001;
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Directed bench for ctrl_bubble_stage. dut uses defaults (STALL_MAX=3, full mask);
// dut2 uses STALL_MAX=2 and BUBBLE_MASK=0x0000FFFF and shares all inputs.
module tb_ctrl_bubble_stage;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl_in;
  logic        valid_in;
  logic        hazard;
  logic [1:0]  stall_cycles;
  logic        flush;
  logic        hold;
  logic [31:0] ctrl_out, ctrl_out2;
  logic        valid_out, valid_out2;
  logic        stall_req, stall_req2;
`ifdef CTRL_BUBBLE_STATS_EN
  logic        stats_clr;
  logic [15:0] bubble_cnt, bubble_cnt2;
`endif

  int checks;
  int failures;

  ctrl_bubble_stage dut (
    .clk          (clk),
    .rst          (rst),
`ifdef CTRL_BUBBLE_STATS_EN
    .stats_clr    (stats_clr),
    .bubble_cnt   (bubble_cnt),
`endif
    .ctrl_in      (ctrl_in),
    .valid_in     (valid_in),
    .hazard       (hazard),
    .stall_cycles (stall_cycles),
    .flush        (flush),
    .hold         (hold),
    .ctrl_out     (ctrl_out),
    .valid_out    (valid_out),
    .stall_req    (stall_req)
  );

  ctrl_bubble_stage #(
    .STALL_MAX   (2),
    .BUBBLE_MASK (32'h0000FFFF)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
`ifdef CTRL_BUBBLE_STATS_EN
    .stats_clr    (stats_clr),
    .bubble_cnt   (bubble_cnt2),
`endif
    .ctrl_in      (ctrl_in),
    .valid_in     (valid_in),
    .hazard       (hazard),
    .stall_cycles (stall_cycles),
    .flush        (flush),
    .hold         (hold),
    .ctrl_out     (ctrl_out2),
    .valid_out    (valid_out2),
    .stall_req    (stall_req2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_in      = 32'h0;
    valid_in     = 1'b0;
    hazard       = 1'b0;
    stall_cycles = 2'd0;
    flush        = 1'b0;
    hold         = 1'b0;
`ifdef CTRL_BUBBLE_STATS_EN
    stats_clr    = 1'b0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    hold = 1'b1;
    rst  = 1'b1;
    #2;
    checks++;
    if (ctrl_out !== 32'h0 || valid_out !== 1'b0 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL reset dut got=%h/%b/%b exp=0/0/0", ctrl_out, valid_out, stall_req);
    end
    checks++;
    if (ctrl_out2 !== 32'h0 || valid_out2 !== 1'b0 || stall_req2 !== 1'b0) begin
      failures++;
      $display("FAIL reset dut2 got=%h/%b/%b exp=0/0/0", ctrl_out2, valid_out2, stall_req2);
    end
    cyc();
    cyc();
    hold = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    // First edge after reset: plain pass.
    ctrl_in  = 32'h0BADF00D;
    valid_in = 1'b1;
    cyc();
    checks++;
    if (ctrl_out !== 32'h0BADF00D || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL first_pass got=%h/%b exp=0badf00d/1", ctrl_out, valid_out);
    end
  endtask

  task automatic test_hazard_two();
    ctrl_in      = 32'hA5A5A5A5;
    valid_in     = 1'b1;
    hazard       = 1'b1;
    stall_cycles = 2'd2;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      failures++;
      $display("FAIL haz2_req1 got=%b exp=1", stall_req);
    end
    cyc();
    hazard = 1'b0;
    checks++;
    if (ctrl_out !== 32'h0 || valid_out !== 1'b0 || ctrl_out2 !== 32'hA5A50000) begin
      failures++;
      $display("FAIL haz2_b1 got=%h/%b/%h exp=0/0/a5a50000", ctrl_out, valid_out, ctrl_out2);
    end
    #1;
    checks++;
    if (stall_req !== 1'b1 || stall_req2 !== 1'b1) begin
      failures++;
      $display("FAIL haz2_req2 got=%b/%b exp=1/1", stall_req, stall_req2);
    end
    cyc();
    checks++;
    if (ctrl_out !== 32'h0 || valid_out !== 1'b0 || valid_out2 !== 1'b0) begin
      failures++;
      $display("FAIL haz2_b2 got=%h/%b/%b exp=0/0/0", ctrl_out, valid_out, valid_out2);
    end
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      failures++;
      $display("FAIL haz2_req3 got=%b exp=0", stall_req);
    end
    cyc();
    checks++;
    if (ctrl_out !== 32'hA5A5A5A5 || valid_out !== 1'b1 || ctrl_out2 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL haz2_pass got=%h/%b/%h exp=a5a5a5a5/1/a5a5a5a5", ctrl_out, valid_out, ctrl_out2);
    end
  endtask

  task automatic test_clamp();
    int  nb1, nb2;
    logic d1, d2;
    nb1 = 0; nb2 = 0; d1 = 1'b0; d2 = 1'b0;
    ctrl_in      = 32'h12345678;
    valid_in     = 1'b1;
    hazard       = 1'b1;
    stall_cycles = 2'd3;
    cyc();
    hazard = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!d1) begin
        if (valid_out === 1'b0) nb1++;
        else d1 = 1'b1;
      end
      if (!d2) begin
        if (valid_out2 === 1'b0) nb2++;
        else d2 = 1'b1;
      end
      cyc();
    end
    checks++;
    if (nb1 !== 3) begin
      failures++;
      $display("FAIL clamp_max3 got=%0d exp=3", nb1);
    end
    checks++;
    if (nb2 !== 2) begin
      failures++;
      $display("FAIL clamp_max2 got=%0d exp=2", nb2);
    end
    // Zero-length request: immediate pass, no stall.
    ctrl_in      = 32'hCAFEF00D;
    hazard       = 1'b1;
    stall_cycles = 2'd0;
    #1;
    checks++;
    if (stall_req !== 1'b0 || stall_req2 !== 1'b0) begin
      failures++;
      $display("FAIL zero_req got=%b/%b exp=0/0", stall_req, stall_req2);
    end
    cyc();
    hazard = 1'b0;
    checks++;
    if (ctrl_out !== 32'hCAFEF00D || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL zero_pass got=%h/%b exp=cafef00d/1", ctrl_out, valid_out);
    end
  endtask

  task automatic test_flush();
    ctrl_in      = 32'h11112222;
    valid_in     = 1'b1;
    hazard       = 1'b1;
    stall_cycles = 2'd3;
    cyc();
    hazard = 1'b0;
    flush  = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b0 || stall_req2 !== 1'b0) begin
      failures++;
      $display("FAIL flush_req got=%b/%b exp=0/0", stall_req, stall_req2);
    end
    cyc();
    flush = 1'b0;
    checks++;
    if (ctrl_out !== 32'h0 || valid_out !== 1'b0 || ctrl_out2 !== 32'h11110000) begin
      failures++;
      $display("FAIL flush_bub got=%h/%b/%h exp=0/0/11110000", ctrl_out, valid_out, ctrl_out2);
    end
    ctrl_in = 32'h33334444;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_run got=%b exp=0", stall_req);
    end
    cyc();
    checks++;
    if (ctrl_out !== 32'h33334444 || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL flush_next got=%h/%b exp=33334444/1", ctrl_out, valid_out);
    end
  endtask

  task automatic test_hold();
    int  nb1, nb2;
    logic d1, d2;
    // Hold after a real instruction keeps it.
    ctrl_in  = 32'h5A5A5A5A;
    valid_in = 1'b1;
    cyc();
    hold    = 1'b1;
    ctrl_in = 32'h77777777;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      failures++;
      $display("FAIL hold_req got=%b exp=1", stall_req);
    end
    cyc();
    checks++;
    if (ctrl_out !== 32'h5A5A5A5A || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL hold_run got=%h/%b exp=5a5a5a5a/1", ctrl_out, valid_out);
    end
    hold = 1'b0;
    // Hold for two cycles inside a stall.
    ctrl_in      = 32'h0F0F0F0F;
    hazard       = 1'b1;
    stall_cycles = 2'd3;
    cyc();
    hazard  = 1'b0;
    hold    = 1'b1;
    ctrl_in = 32'hFFFFFFFF;
    cyc();
    cyc();
    checks++;
    if (ctrl_out !== 32'h0 || valid_out !== 1'b0 || ctrl_out2 !== 32'h0F0F0000) begin
      failures++;
      $display("FAIL hold_stall got=%h/%b/%h exp=0/0/0f0f0000", ctrl_out, valid_out, ctrl_out2);
    end
    hold    = 1'b0;
    ctrl_in = 32'h0F0F0F0F;
    nb1 = 1; nb2 = 1; d1 = 1'b0; d2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (!d1) begin
        if (valid_out === 1'b0) nb1++;
        else d1 = 1'b1;
      end
      if (!d2) begin
        if (valid_out2 === 1'b0) nb2++;
        else d2 = 1'b1;
      end
    end
    checks++;
    if (nb1 !== 3 || nb2 !== 2) begin
      failures++;
      $display("FAIL hold_total got=%0d/%0d exp=3/2", nb1, nb2);
    end
    checks++;
    if (ctrl_out !== 32'h0F0F0F0F || valid_out !== 1'b1) begin
      failures++;
      $display("FAIL hold_after got=%h/%b exp=0f0f0f0f/1", ctrl_out, valid_out);
    end
  endtask

  task automatic test_reset_mid_stall();
    ctrl_in      = 32'hDEAD0000;
    valid_in     = 1'b1;
    hazard       = 1'b1;
    stall_cycles = 2'd3;
    cyc();
    hazard = 1'b0;
    checks++;
    if (ctrl_out2 !== 32'hDEAD0000 || stall_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got=%h/%b exp=dead0000/1", ctrl_out2, stall_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ctrl_out !== 32'h0 || valid_out !== 1'b0 || stall_req !== 1'b0 || ctrl_out2 !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst got=%h/%b/%b/%h exp=0/0/0/0", ctrl_out, valid_out, stall_req, ctrl_out2);
    end
    rst     = 1'b0;
    ctrl_in = 32'h01020304;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      failures++;
      $display("FAIL mid_req got=%b exp=0", stall_req);
    end
    cyc();
    checks++;
    if (ctrl_out !== 32'h01020304 || valid_out !== 1'b1 || valid_out2 !== 1'b1) begin
      failures++;
      $display("FAIL mid_pass got=%h/%b/%b exp=01020304/1/1", ctrl_out, valid_out, valid_out2);
    end
  endtask

`ifdef CTRL_BUBBLE_STATS_EN
  task automatic test_stats();
    idle_inputs();
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    flush     = 1'b1;
    cyc(); cyc(); cyc();
    flush = 1'b0;
    hold  = 1'b1;
    cyc();
    hold = 1'b0;
    checks++;
    if (bubble_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stats_3 got=%0d exp=3", bubble_cnt);
    end
    flush = 1'b1;
    for (int i = 0; i < 70000; i++) cyc();
    checks++;
    if (bubble_cnt !== 16'hFFFF || bubble_cnt2 !== 16'hFFFF) begin
      failures++;
      $display("FAIL stats_sat got=%h/%h exp=ffff/ffff", bubble_cnt, bubble_cnt2);
    end
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    flush     = 1'b0;
    checks++;
    if (bubble_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL stats_clr got=%h exp=0000", bubble_cnt);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_hazard_two();
    test_clamp();
    test_flush();
    test_hold();
    test_reset_mid_stall();
`ifdef CTRL_BUBBLE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_bubble_stage.md
CTRL_BUBBLE_STAGE -- requirements
Module: ctrl_bubble_stage

Interface
REQ-001 Parameter CTRL_W, default 32: width of the decoded control bundle carried ID->EX.
REQ-002 Parameter STALL_MAX, default 3: maximum bubbles per hazard request; SHALL be at least 1.
REQ-003 Parameter BUBBLE_MASK, CTRL_W bits, default all ones: control bits forced to 0 in a bubble; unmasked bits pass through.
REQ-004 Parameter CNT_W = clog2(STALL_MAX+1), derived, not overridable.
REQ-005 Clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Rst  input  1  asynchronous, active-high reset.
REQ-007 ctrl_in  input  CTRL_W  decoded control bundle from ID.
REQ-008 valid_in  input  1  ctrl_in carries a real instruction.
REQ-009 hazard  input  1  load-use or multi-cycle hazard detected for the instruction in ID.
REQ-010 stall_cycles  input  CNT_W  number of bubbles requested with hazard.
REQ-011 flush  input  1  squash the ID instruction (branch/jump redirect).
REQ-012 hold  input  1  downstream freeze; the stage keeps its contents.
REQ-013 ctrl_out  output  CTRL_W  registered control bundle to EX.
REQ-014 valid_out  output  1  registered; ctrl_out is a real instruction.
REQ-015 stall_req  output  1  combinational; PC and IF/ID SHALL hold while high.

Function
REQ-016 States SHALL be RUN and STALL, with a CNT_W-bit remaining-bubble counter cnt.
REQ-017 Bubble: ctrl_out <= ctrl_in & ~BUBBLE_MASK, valid_out <= 0.
REQ-018 Pass: ctrl_out <= ctrl_in, valid_out <= valid_in.
REQ-019 Priority each cycle SHALL be flush > hold > hazard > pass.
REQ-020 flush, any state: bubble; go to RUN; cnt <= 0; stall_req = 0 that cycle.
REQ-021 hold without flush: ctrl_out, valid_out, state and cnt unchanged; stall_req = 1.
REQ-022 RUN, hazard & valid_in & stall_cycles != 0: bubble; stall_req = 1; cnt <= eff-1, where eff = min(stall_cycles, STALL_MAX); go to STALL if eff > 1, else stay in RUN.
REQ-023 RUN, hazard with stall_cycles = 0 or valid_in = 0: treated as pass; stall_req = 0.
REQ-024 STALL: bubble; stall_req = 1; cnt decrements; at cnt = 1, cnt <= 0 and go to RUN; hazard is ignored.
REQ-025 A hazard SHALL yield exactly eff consecutive bubbles (excluding hold cycles).
REQ-026 The held instruction SHALL pass in the first RUN cycle after the last bubble.
REQ-027 Latency ctrl_in -> ctrl_out: 1 cycle.

Reset
REQ-028 While Rst is high: ctrl_out = 0, valid_out = 0, state = RUN, cnt = 0, stall_req = 0, bubble_cnt = 0; this applies immediately, including mid-STALL.
REQ-029 The first edge after Rst deasserts SHALL follow normal RUN rules.

Configuration
REQ-030 Macro CTRL_BUBBLE_STATS_EN defined: adds input stats_clr (1) and output bubble_cnt (16).
REQ-031 With the macro, bubble_cnt SHALL increment on each registered bubble (flush or hazard), not on hold.
REQ-032 With the macro, bubble_cnt SHALL saturate at 0xFFFF; stats_clr zeroes it synchronously and wins over an increment.
REQ-033 Macro undefined: those ports and the counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Package ctrl_bubble_pkg SHALL hold the state enum (RUN, STALL), the default STALL_MAX and a clog2 helper.
REQ-035 Sub-module bubble_stall_counter SHALL implement cnt load/decrement/clear with a done flag (cnt = 1); the parent owns the FSM and datapath.

Verification
REQ-036 Reset mid-STALL: Rst at cnt = 2 -> ctrl_out = 0, valid_out = 0, stall_req = 0 at once; normal pass on the next edge.
REQ-037 Hazard, stall_cycles = 2, ctrl_in = 0xA5A5A5A5: two bubble cycles with stall_req = 1, then ctrl_out = 0xA5A5A5A5, valid_out = 1.
REQ-038 stall_cycles = 3 with STALL_MAX = 2: exactly 2 bubbles; with stall_cycles = 0: immediate pass and no stall_req.
REQ-039 Flush during the 2nd of 3 bubbles: bubble registered, state RUN, stall_req = 0 that cycle; next ctrl_in passes.
REQ-040 Hold for 2 cycles inside STALL: ctrl_out frozen, total bubbles still eff; BUBBLE_MASK = 0x0000FFFF leaves the upper 16 bits passing in bubbles.
REQ-041 Stats build: 70000 flush cycles -> bubble_cnt = 0xFFFF; stats_clr together with a bubble -> bubble_cnt = 0.
